controlador_arranque_rampa: RTL

- Sequencer for the motor soft-start ramp stage.
- Takes operator start/stop commands and the Rapido/Lento mode selection.
- Steps the one-hot ramp outputs out_30 -> out_50 -> out_100 with programmable dwell times, ramps down through out_30 on stop, and latches faults.
- Sits between the operator/PLC command inputs and the power-stage drive enables.

---
 rtl/controlador_arranque_rampa_if.sv | 26 ++
 rtl/controlador_arranque_rampa.sv | 123 ++++++++++++
 2 files changed

// File: rtl/controlador_arranque_rampa_if.sv
// Command/drive bundle of the soft-start ramp sequencer.
// The master side issues operator commands; the slave side returns the drive enables.
interface controlador_arranque_rampa_if;
   logic       start;
   logic       stop;
   logic       Rapido;
   logic       Lento;
   logic       falla_in;
   logic       ack_falla;
   logic       out_30;
   logic       out_50;
   logic       out_100;
   logic       en_marcha;
   logic       falla;
   logic [2:0] estado;

   modport master (
      output start, stop, Rapido, Lento, falla_in, ack_falla,
      input  out_30, out_50, out_100, en_marcha, falla, estado
   );

   modport slave (
      input  start, stop, Rapido, Lento, falla_in, ack_falla,
      output out_30, out_50, out_100, en_marcha, falla, estado
   );
endinterface

// File: rtl/controlador_arranque_rampa.sv
// Motor soft-start sequencer: steps 30% -> 50% -> 100% with mode-dependent dwell,
// ramps down through 30% on stop and latches external faults until acknowledged.
module controlador_arranque_rampa #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DWELL_RAPIDO = 4,
   parameter int unsigned DWELL_LENTO  = 12,
   parameter int unsigned DWELL_PARADA = 6
) (
   input  logic                          clk,
   input  logic                          reset,
   controlador_arranque_rampa_if.slave   io_bus
);

   typedef enum logic [2:0] {
      StParado  = 3'd0,
      StR30     = 3'd1,
      StR50     = 3'd2,
      StM100    = 3'd3,
      StDesacel = 3'd4,
      StFalla   = 3'd5
   } estado_t;

   localparam logic [CNT_W-1:0] CntRapido = CNT_W'(DWELL_RAPIDO - 1);
   localparam logic [CNT_W-1:0] CntLento  = CNT_W'(DWELL_LENTO - 1);
   localparam logic [CNT_W-1:0] CntParada = CNT_W'(DWELL_PARADA - 1);

   estado_t          r_estado, w_estado_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic             r_modo, w_modo_d;  // 1 = fast ramp
   logic [CNT_W-1:0] w_recarga;

   assign w_recarga = r_modo ? CntRapido : CntLento;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_estado <= StParado;
         r_cnt    <= '0;
         r_modo   <= 1'b0;
      end else begin
         r_estado <= w_estado_d;
         r_cnt    <= w_cnt_d;
         r_modo   <= w_modo_d;
      end
   end

   always_comb begin
      w_estado_d = r_estado;
      w_cnt_d    = r_cnt;
      w_modo_d   = r_modo;
      case (r_estado)
         StParado: begin
            if (io_bus.falla_in) begin
               w_estado_d = StFalla;
               w_cnt_d    = '0;
            end else if (io_bus.stop) begin
               w_estado_d = StParado;
            end else if (io_bus.start && io_bus.Rapido) begin
               w_estado_d = StR30;
               w_modo_d   = 1'b1;
               w_cnt_d    = CntRapido;
            end else if (io_bus.start && io_bus.Lento) begin
               w_estado_d = StR30;
               w_modo_d   = 1'b0;
               w_cnt_d    = CntLento;
            end
         end
         StR30, StR50: begin
            if (io_bus.falla_in) begin
               w_estado_d = StFalla;
               w_cnt_d    = '0;
            end else if (io_bus.stop) begin
               w_estado_d = StDesacel;
               w_cnt_d    = CntParada;
            end else if (r_cnt == '0) begin
               w_estado_d = (r_estado == StR30) ? StR50 : StM100;
               w_cnt_d    = (r_estado == StR30) ? w_recarga : '0;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         StM100: begin
            if (io_bus.falla_in) begin
               w_estado_d = StFalla;
               w_cnt_d    = '0;
            end else if (io_bus.stop) begin
               w_estado_d = StDesacel;
               w_cnt_d    = CntParada;
            end
         end
         StDesacel: begin
            if (io_bus.falla_in) begin
               w_estado_d = StFalla;
               w_cnt_d    = '0;
            end else if (r_cnt == '0) begin
               w_estado_d = StParado;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         StFalla: begin
            w_cnt_d = '0;
            if (io_bus.ack_falla && !io_bus.falla_in) begin
               w_estado_d = StParado;
            end
         end
         default: begin
            w_estado_d = StParado;
            w_cnt_d    = '0;
         end
      endcase
   end

   always_comb begin
      io_bus.out_30    = (r_estado == StR30) || (r_estado == StDesacel);
      io_bus.out_50    = (r_estado == StR50);
      io_bus.out_100   = (r_estado == StM100);
      io_bus.en_marcha = (r_estado == StR30) || (r_estado == StR50) ||
                         (r_estado == StM100) || (r_estado == StDesacel);
      io_bus.falla     = (r_estado == StFalla);
      io_bus.estado    = r_estado;
   end

endmodule
